// File: rtl/compare_sort_sequencer.sv
// Bubble-sorts a small register array in place with one shared unsigned comparator.
// Values are streamed in, sorted on start, and read back through a combinational port.
module compare_sort_sequencer #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [WIDTH-1:0]         load_data,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data,
  output logic [7:0]               swap_count
);
  // state | meaning
  // IDLE  | accept loads, wait for start with a full array
  // CMP   | compare mem[j] against mem[j+1]
  // SWAP  | exchange mem[j] and mem[j+1]
  // DONE  | one-cycle completion pulse, load count cleared
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMP  = 2'd1;
  localparam logic [1:0] SWAP = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_PASS = AW'(DEPTH - 2);

  logic [1:0]       state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count;
  logic [AW-1:0]    j;
  logic [AW-1:0]    j_nxt;
  logic [AW-1:0]    pass;
  logic [AW-1:0]    last_j;
  logic             swapped;
  logic             gt;
  logic             end_pass;
  logic             finish;
  logic             advance;

  assign j_nxt    = j + 1'b1;
  assign gt       = mem[j] > mem[j_nxt];
  assign last_j   = LAST_PASS - pass;
  assign end_pass = (j == last_j);
  // A SWAP cycle counts as a swap in this pass even before swapped is registered.
  assign finish   = !(swapped || state == SWAP) || (pass == LAST_PASS);
  assign advance  = (state == CMP && !gt) || (state == SWAP);

  assign load_ready = (state == IDLE) && (count < FULL);
  assign busy       = (state == CMP) || (state == SWAP);
  assign done       = (state == DONE);
  assign rd_data    = mem[rd_addr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      j          <= '0;
      pass       <= '0;
      swapped    <= 1'b0;
      swap_count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid && load_ready) begin
            mem[count[AW-1:0]] <= load_data;
            count              <= count + 1'b1;
          end
          if (start && count == FULL) begin
            j          <= '0;
            pass       <= '0;
            swapped    <= 1'b0;
            swap_count <= '0;
            state      <= CMP;
          end
        end
        CMP: begin
          if (gt) state <= SWAP;
        end
        SWAP: begin
          mem[j]     <= mem[j_nxt];
          mem[j_nxt] <= mem[j];
          swapped    <= 1'b1;
          if (swap_count != 8'hFF) swap_count <= swap_count + 1'b1;
        end
        DONE: begin
          count <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (advance) begin
        if (!end_pass) begin
          j     <= j_nxt;
          state <= CMP;
        end else if (finish) begin
          state <= DONE;
        end else begin
          pass    <= pass + 1'b1;
          j       <= '0;
          swapped <= 1'b0;
          state   <= CMP;
        end
      end
    end
  end
endmodule

// File: tb/tb_compare_sort_sequencer.sv
// Scoreboard bench for compare_sort_sequencer: a bubble-sort model predicts the
// sorted contents, swap count and done latency for each accepted start.
module tb_compare_sort_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [1:0] load_data = '0;
  logic       start = 1'b0;
  logic       busy;
  logic       done;
  logic [1:0] rd_addr = '0;
  logic [1:0] rd_data;
  logic [7:0] swap_count;

  typedef struct packed {
    logic [7:0] vals;
    logic [7:0] sc;
    logic [7:0] lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  compare_sort_sequencer #(.WIDTH(2), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .swap_count(swap_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] pk(input logic [1:0] a, input logic [1:0] b,
                                    input logic [1:0] c, input logic [1:0] d);
    return {d, c, b, a};
  endfunction

  // Bubble sort with early exit; latency = compares + swaps + 1.
  function automatic exp_t model(input logic [7:0] in);
    int a[4];
    int sc;
    int cmps;
    bit sw;
    logic [7:0] tmp;
    exp_t e;
    tmp = in;
    for (int i = 0; i < 4; i++) a[i] = int'(tmp[2*i +: 2]);
    sc = 0;
    cmps = 0;
    for (int p = 0; p < 3; p++) begin
      sw = 1'b0;
      for (int k = 0; k <= 2 - p; k++) begin
        cmps++;
        if (a[k] > a[k+1]) begin
          int t;
          t = a[k]; a[k] = a[k+1]; a[k+1] = t;
          sc++;
          sw = 1'b1;
        end
      end
      if (!sw) break;
    end
    e.vals = pk(2'(a[0]), 2'(a[1]), 2'(a[2]), 2'(a[3]));
    e.sc   = 8'(sc);
    e.lat  = 8'(cmps + sc + 1);
    return e;
  endfunction

  task automatic load_one(input logic [1:0] v);
    int t;
    load_valid = 1'b1;
    load_data  = v;
    t = 0;
    while (!load_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) check("load_ready_timeout", 0, 1);
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic load4(input logic [7:0] vals);
    logic [7:0] v;
    v = vals;
    for (int i = 0; i < 4; i++) load_one(v[2*i +: 2]);
  endtask

  task automatic start_sort(input logic [7:0] vals);
    exp_q.push_back(model(vals));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  // Entered one cycle after the start edge (k0 = 1) or later.
  task automatic wait_done(input string tag, input int k0);
    int   k;
    exp_t e;
    logic [7:0] v;
    k = k0;
    while (!done && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (!done) begin
      check({tag, "_done_timeout"}, 0, 1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected_done"}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_latency"}, k, int'(e.lat));
    check({tag, "_busy_in_done"}, busy, 0);
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_load_ready_after"}, load_ready, 1);
    check({tag, "_swap_count"}, swap_count, int'(e.sc));
    v = e.vals;
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      check($sformatf("%s_rd%0d", tag, i), rd_data, int'(v[2*i +: 2]));
    end
  endtask

  initial begin
    int seen;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_load_ready", load_ready, 1);
    check("rst_swap_count", swap_count, 0);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      check($sformatf("rst_rd%0d", i), rd_data, 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // already sorted, reverse sorted, duplicates
    load4(pk(2'd0, 2'd1, 2'd2, 2'd3));
    start_sort(pk(2'd0, 2'd1, 2'd2, 2'd3));
    wait_done("sorted", 1);

    load4(pk(2'd3, 2'd2, 2'd1, 2'd0));
    start_sort(pk(2'd3, 2'd2, 2'd1, 2'd0));
    wait_done("reverse", 1);

    load4(pk(2'd2, 2'd2, 2'd1, 2'd2));
    start_sort(pk(2'd2, 2'd2, 2'd1, 2'd2));
    wait_done("dups", 1);

    // start with a partial array, then with the final load, then accepted
    load_one(2'd2);
    load_one(2'd0);
    load_one(2'd3);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("partial_start_busy", busy, 0);
    @(posedge clk); #1;
    check("partial_start_busy2", busy, 0);
    load_valid = 1'b1;
    load_data  = 2'd1;
    start      = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    start      = 1'b0;
    check("start_with_last_load_busy", busy, 0);
    check("full_load_ready", load_ready, 0);
    start_sort(pk(2'd2, 2'd0, 2'd3, 2'd1));
    wait_done("late_start", 1);

    // load_valid held and start pulsed while sorting
    load4(pk(2'd3, 2'd2, 2'd1, 2'd0));
    exp_q.push_back(model(pk(2'd3, 2'd2, 2'd1, 2'd0)));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("hold_busy_after_start", busy, 1);
    load_valid = 1'b1;
    load_data  = 2'd3;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("hold_load_ready%0d", i), load_ready, 0);
      start = (i == 1);
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    start      = 1'b0;
    wait_done("hold", 5);

    // reset mid-sort
    load4(pk(2'd3, 2'd2, 2'd1, 2'd0));
    start_sort(pk(2'd3, 2'd2, 2'd1, 2'd0));
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    check("midrst_busy", busy, 0);
    check("midrst_load_ready", load_ready, 1);
    check("midrst_swap_count", swap_count, 0);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      check($sformatf("midrst_rd%0d", i), rd_data, 0);
    end
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("midrst_no_done", seen, 0);
    load4(pk(2'd3, 2'd1, 2'd0, 2'd2));
    start_sort(pk(2'd3, 2'd1, 2'd0, 2'd2));
    wait_done("after_rst", 1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
